// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_access_ctrl: four request/response clients onto a 1W/4R sync RAM.
// Rev 1.0 - per-client IDLE/RD_WAIT/RSP FSMs, one round-robin write port.
// ----------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid   [4],
  output logic              req_ready   [4],
  input  logic              req_we      [4],
  input  logic [ADDR_W-1:0] req_addr    [4],
  input  logic [DATA_W-1:0] req_wdata   [4],
  input  logic [MASK_W-1:0] req_mask    [4],
  output logic              rsp_valid   [4],
  input  logic              rsp_ready   [4],
  output logic [DATA_W-1:0] rsp_rdata   [4],
  output logic              ram_wr_en,
  output logic [MASK_W-1:0] ram_wr_mask,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en   [4],
  output logic [ADDR_W-1:0] ram_rd_addr [4],
  input  logic [DATA_W-1:0] ram_rd_data [4]
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RSP     = 2'd2;

  logic [1:0]        state_q [4];
  logic [1:0]        state_d [4];
  logic [DATA_W-1:0] rdata_q [4];
  logic [DATA_W-1:0] rdata_d [4];
  logic [1:0]        last_grant_q;
  logic [1:0]        last_grant_d;

  logic [3:0]        wr_req;
  logic [3:0]        grant;
  logic              wr_any;
  logic [1:0]        wr_idx;
  logic [1:0]        arb_cand;
  logic              rd_acc [4];

  // Request decode and arbitration; everything is gated by reset_n so no
  // request can be accepted while the block is held in reset.
  always_comb begin
    wr_req   = 4'b0000;
    wr_any   = 1'b0;
    wr_idx   = last_grant_q;
    arb_cand = last_grant_q;
    for (int i = 0; i < 4; i++) begin
      wr_req[i] = reset_n && (state_q[i] == ST_IDLE) && req_valid[i] && req_we[i];
    end
    for (int k = 1; k <= 4; k++) begin
      arb_cand = last_grant_q + k[1:0];
      if (!wr_any && wr_req[arb_cand]) begin
        wr_any = 1'b1;
        wr_idx = arb_cand;
      end
    end
    grant = wr_any ? (4'b0001 << wr_idx) : 4'b0000;
    // A read colliding with this cycle's granted write waits one cycle so it
    // never observes the RAM's undefined read-under-write data.
    for (int i = 0; i < 4; i++) begin
      rd_acc[i] = reset_n && (state_q[i] == ST_IDLE) && req_valid[i] && !req_we[i]
                  && !(wr_any && (req_addr[wr_idx] == req_addr[i]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        rdata_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  always_comb begin
    last_grant_d = wr_any ? wr_idx : last_grant_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      rdata_d[i] = rdata_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (grant[i]) begin
            state_d[i] = ST_RSP;
            rdata_d[i] = '0;
          end else if (rd_acc[i]) begin
            state_d[i] = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rdata_d[i] = ram_rd_data[i];
          state_d[i] = ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_wr_en   = wr_any;
    ram_wr_addr = req_addr[wr_idx];
    ram_wr_data = req_wdata[wr_idx];
    ram_wr_mask = req_mask[wr_idx];
    for (int i = 0; i < 4; i++) begin
      req_ready[i]   = req_we[i] ? grant[i] : rd_acc[i];
      ram_rd_en[i]   = rd_acc[i];
      ram_rd_addr[i] = req_addr[i];
      rsp_valid[i]   = (state_q[i] == ST_RSP);
      rsp_rdata[i]   = rdata_q[i];
    end
  end

endmodule
`default_nettype wire
